// File: rtl/exibidor_pkg.sv
// Shared definitions for the sequence display block: FSM state codes,
// default timing parameters and the timer width.
package exibidor_pkg;

    localparam int T_ON_DEF  = 50;
    localparam int T_OFF_DEF = 25;
    localparam int TIMER_W   = 12;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        CARREGA = 4'd1,
        ACENDE  = 4'd2,
        APAGA   = 4'd3,
        PROXIMO = 4'd4,
        FIM     = 4'd5
    } estado_t;

endpackage

// File: rtl/contador_m.sv
// Free-running up counter with synchronous clear and count enable.
// Clear has priority over count.
module contador_m #(
    parameter int W = 12
) (
    input  logic         clock,
    input  logic         zera_s,
    input  logic         conta,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Count register: clear wins, otherwise increment when enabled
    always_ff @(posedge clock) begin
        if (zera_s) begin
            q_q <= '0;
        end else if (conta) begin
            q_q <= q_q + 1'b1;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/exibidor_sequencia.sv
// Sequence display: walks ROM addresses 0..rodada, lighting each element
// for T_ON cycles and (optionally) blanking T_OFF cycles between them.
// Build option: define EXIBIDOR_APAGA_EN to enable the APAGA blank phase;
// without it ACENDE goes straight to PROXIMO and T_OFF is unused.
module exibidor_sequencia
    import exibidor_pkg::*;
#(
    parameter int T_ON  = T_ON_DEF,
    parameter int T_OFF = T_OFF_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] rodada,
    input  logic [3:0] mem_dado,
    output logic [3:0] mem_endereco,
    output logic [3:0] leds,
    output logic       exibindo,
    output logic       pronto,
    output logic [3:0] db_estado
);

    // Timer value on the last cycle of each timed phase
    localparam logic [TIMER_W-1:0] TON_LAST  = TIMER_W'(T_ON - 1);
    localparam logic [TIMER_W-1:0] TOFF_LAST = TIMER_W'(T_OFF - 1);

    estado_t            estado_q, estado_d;
    logic [3:0]         indice_q, indice_d;
    logic [3:0]         rodada_q, rodada_d;
    logic [TIMER_W-1:0] timer;
    logic               timer_zera, timer_conta;

`ifndef EXIBIDOR_APAGA_EN
    // Blank phase compiled out; keep the parameter referenced
    logic unused_toff;
    assign unused_toff = ^TOFF_LAST;
`endif

    // Timer restarts on every state change (and on reset), runs only in timed phases
    assign timer_zera  = reset || (estado_d != estado_q);
    assign timer_conta = (estado_q == ACENDE) || (estado_q == APAGA);

    contador_m #(
        .W(TIMER_W)
    ) u_timer (
        .clock (clock),
        .zera_s(timer_zera),
        .conta (timer_conta),
        .q_o   (timer)
    );

    // State, index and latched last-index registers
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
            indice_q <= 4'd0;
            rodada_q <= 4'd0;
        end else begin
            estado_q <= estado_d;
            indice_q <= indice_d;
            rodada_q <= rodada_d;
        end
    end

    // Next-state, index update and outputs; outputs forced idle while in reset
    always_comb begin
        estado_d     = estado_q;
        indice_d     = indice_q;
        rodada_d     = rodada_q;
        leds         = 4'd0;
        mem_endereco = indice_q;
        exibindo     = (estado_q != INICIAL);
        pronto       = (estado_q == FIM);
        db_estado    = estado_q;

        case (estado_q)
            INICIAL: begin
                if (iniciar) begin
                    estado_d = CARREGA;
                    indice_d = 4'd0;
                    rodada_d = rodada;
                end
            end
            // One cycle for the synchronous ROM to present the held address
            CARREGA: estado_d = ACENDE;
            ACENDE: begin
                leds = mem_dado;
                if (timer == TON_LAST) begin
`ifdef EXIBIDOR_APAGA_EN
                    estado_d = APAGA;
`else
                    estado_d = PROXIMO;
`endif
                end
            end
`ifdef EXIBIDOR_APAGA_EN
            APAGA: begin
                if (timer == TOFF_LAST) begin
                    estado_d = PROXIMO;
                end
            end
`endif
            // Compare before incrementing so the index never wraps past 15
            PROXIMO: begin
                if (indice_q == rodada_q) begin
                    estado_d = FIM;
                end else begin
                    indice_d = indice_q + 4'd1;
                    estado_d = CARREGA;
                end
            end
            FIM:     estado_d = INICIAL;
            default: estado_d = INICIAL;
        endcase

        if (reset) begin
            leds         = 4'd0;
            mem_endereco = 4'd0;
            exibindo     = 1'b0;
            pronto       = 1'b0;
            db_estado    = INICIAL;
        end
    end

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Self-checking bench: two instances (T_ON/T_OFF = 3/2 and 1/1) share the
// stimulus; every cycle is compared with a per-cycle model derived from
// element position arithmetic.
module tb_exibidor_sequencia;

`ifdef EXIBIDOR_APAGA_EN
    localparam int APAGA_EN = 1;
`else
    localparam int APAGA_EN = 0;
`endif
    localparam int TON_A  [2] = '{3, 1};
    localparam int TOFF_A [2] = '{2, 1};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] rodada = 4'd0;
    logic [3:0] rom_m [16];

    logic [3:0] mem_dado [2];
    logic [3:0] addr_w   [2];
    logic [3:0] leds_w   [2];
    logic       exib_w   [2];
    logic       pronto_w [2];
    logic [3:0] db_w     [2];

    int n_tests = 0;
    int n_fail  = 0;
    int prev_addr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        exibidor_sequencia #(
            .T_ON (TON_A[g]),
            .T_OFF(TOFF_A[g])
        ) dut (
            .clock       (clk),
            .reset       (reset),
            .iniciar     (iniciar),
            .rodada      (rodada),
            .mem_dado    (mem_dado[g]),
            .mem_endereco(addr_w[g]),
            .leds        (leds_w[g]),
            .exibindo    (exib_w[g]),
            .pronto      (pronto_w[g]),
            .db_estado   (db_w[g])
        );

        // External ROM with one-cycle read latency
        always @(posedge clk) mem_dado[g] <= rom_m[addr_w[g]];
    end

    // {leds, mem_endereco, exibindo, pronto, db_estado}
    function automatic logic [13:0] obs(input int d);
        return {leds_w[d], addr_w[d], exib_w[d], pronto_w[d], db_w[d]};
    endfunction

    function automatic int elem_len(input int d);
        return 2 + TON_A[d] + (APAGA_EN ? TOFF_A[d] : 0);
    endfunction

    // Expected outputs c cycles after the cycle in which iniciar is sampled
    function automatic logic [13:0] expv(input int d, input int c, input int r, input int pa);
        int L, k, total, e, p;
        logic [3:0] st, lv;
        L = elem_len(d);
        if (c == 0) return {4'd0, 4'(pa), 1'b0, 1'b0, 4'd0};
        k = c - 1;
        total = (r + 1) * L;
        if (k < total) begin
            e = k / L;
            p = k % L;
            if (p == 0)             st = 4'd1;
            else if (p <= TON_A[d]) st = 4'd2;
            else if (p == L - 1)    st = 4'd4;
            else                    st = 4'd3;
            lv = (st == 4'd2) ? rom_m[e] : 4'd0;
            return {lv, 4'(e), 1'b1, 1'b0, st};
        end
        if (k == total) return {4'd0, 4'(r), 1'b1, 1'b1, 4'd5};
        return {4'd0, 4'(r), 1'b0, 1'b0, 4'd0};
    endfunction

    function automatic int seq_end(input int r);
        int m0, m1;
        m0 = (r + 1) * elem_len(0) + 2;
        m1 = (r + 1) * elem_len(1) + 2;
        return (m0 > m1) ? m0 : m1;
    endfunction

    task automatic fill_rom();
        for (int i = 0; i < 16; i++) rom_m[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        iniciar = 1'b1;
        rodada = 4'hF;
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (obs(d) !== 14'h0) begin
                n_fail++;
                $display("FAIL reset_held dut%0d got %h exp %h", d, obs(d), 14'h0);
            end
        end
        reset = 1'b0;
        iniciar = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (obs(d) !== 14'h0) begin
                n_fail++;
                $display("FAIL reset_after dut%0d got %h exp %h", d, obs(d), 14'h0);
            end
        end
        prev_addr = 0;
    endtask

    // Full sequence; with disturb, iniciar re-pulses and rodada wanders mid-run
    task automatic test_seq(input string name, input int r, input bit disturb);
        int cmax;
        logic [13:0] o, e;
        cmax = seq_end(r);
        for (int c = 0; c <= cmax; c++) begin
            if (c > 0) @(negedge clk);
            iniciar = (c == 0) || (disturb && c >= 2 && c <= 4);
            if (c == 0) rodada = 4'(r);
            else if (disturb) rodada = 4'($urandom_range(0, 15));
            #1;
            for (int d = 0; d < 2; d++) begin
                o = obs(d);
                e = expv(d, c, r, prev_addr);
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL %s dut%0d c=%0d got %h exp %h", name, d, c, o, e);
                end
            end
        end
        iniciar = 1'b0;
        prev_addr = r;
    endtask

    // Reset during ACENDE of element 1 of the slower instance
    task automatic test_reset_abort();
        int r, cstop;
        logic [13:0] o, e;
        r = 3;
        cstop = elem_len(0) + 2;
        for (int c = 0; c <= cstop; c++) begin
            if (c > 0) @(negedge clk);
            iniciar = (c == 0);
            rodada = 4'(r);
            #1;
            o = obs(0);
            e = expv(0, c, r, prev_addr);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL abort_pre c=%0d got %h exp %h", c, o, e);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            for (int d = 0; d < 2; d++) begin
                n_tests++;
                if (obs(d) !== 14'h0) begin
                    n_fail++;
                    $display("FAIL abort_idle dut%0d c=%0d got %h exp %h", d, c, obs(d), 14'h0);
                end
            end
            @(negedge clk);
        end
        prev_addr = 0;
        fill_rom();
        test_seq("abort_restart", 1, 1'b0);
    endtask

    initial begin
        fill_rom();
        test_reset();

        fill_rom();
        rom_m[0] = 4'd8;
        test_seq("rodada_zero", 0, 1'b0);

        rom_m[0] = 4'd1;
        rom_m[1] = 4'd2;
        rom_m[2] = 4'd4;
        test_seq("example_3elem", 2, 1'b0);

        fill_rom();
        test_seq("rodada_15", 15, 1'b0);

        fill_rom();
        test_seq("no_restart", 2, 1'b1);

        test_reset_abort();

        for (int i = 0; i < 6; i++) begin
            fill_rom();
            test_seq("random", $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
